// File: rtl/alien_march_ctrl.sv
// rtl/alien_march_ctrl.sv - formation march controller: frame divider, step sizing, edge drop, halt
module alien_march_ctrl #(
    parameter logic [9:0] FORM_W     = 10'd295,
    parameter logic [9:0] FORM_H     = 10'd120,
    parameter logic [9:0] START_X    = 10'd135,
    parameter logic [9:0] START_Y    = 10'd120,
    parameter logic [9:0] X_MIN      = 10'd5,
    parameter logic [9:0] X_MAX      = 10'd634,
    parameter logic [9:0] Y_LIMIT    = 10'd440,
    parameter logic [3:0] BASE_DIV   = 4'd3,
    parameter logic [1:0] DROP_PX    = 2'd2,
    parameter logic [5:0] FAST_THR   = 6'd16,
    parameter logic [5:0] FASTER_THR = 6'd4
) (
    input  logic       Pclk,
    input  logic       rst_n,
    input  logic [9:0] xx,
    input  logic [9:0] yy,
    input  logic       run,
    input  logic [5:0] alive_count,
    output logic [1:0] X_off,
    output logic [1:0] Y_off,
    output logic       Dir,
    output logic       move_stb,
    output logic [9:0] FormX,
    output logic [9:0] FormY,
    output logic       invaded,
    output logic       cleared
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MARCH_R = 3'd1,
        S_MARCH_L = 3'd2,
        S_DROP    = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt, r_lim, w_lim_nxt, w_cnt_inc;
    logic [9:0] r_x, w_x_nxt, r_y, w_y_nxt;
    logic [1:0] r_xoff, w_xoff_nxt, r_yoff, w_yoff_nxt;
    logic       r_dir, w_dir_nxt, r_stb, w_stb_nxt;
    logic       r_inv, w_inv_nxt, r_clr, w_clr_nxt;

    logic       w_tick, w_fire, w_hit_r, w_hit_l, w_edge;
    logic [1:0] w_s;
    logic [10:0] w_x11, w_s11, w_y_after;

    assign w_tick    = (xx == 10'd639) && (yy == 10'd479);
    assign w_cnt_inc = r_cnt + 4'd1;
    assign w_fire    = (w_cnt_inc >= r_lim);

    always_comb begin
        w_s = 2'd1;
        if (alive_count <= FASTER_THR) begin
            w_s = 2'd3;
        end else if (alive_count <= FAST_THR) begin
            w_s = 2'd2;
        end
    end

    // Position sums carried in 11 bits so edge and invasion compares never wrap.
    assign w_x11     = {1'b0, r_x};
    assign w_s11     = {9'd0, w_s};
    assign w_hit_r   = (w_x11 + {1'b0, FORM_W} + w_s11) > {1'b0, X_MAX};
    assign w_hit_l   = w_x11 < ({1'b0, X_MIN} + w_s11);
    assign w_edge    = r_dir ? w_hit_r : w_hit_l;
    assign w_y_after = w_edge ? ({1'b0, r_y} + {9'd0, DROP_PX}) : {1'b0, r_y};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lim_nxt   = r_lim;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dir_nxt   = r_dir;
        w_xoff_nxt  = r_xoff;
        w_yoff_nxt  = r_yoff;
        w_stb_nxt   = 1'b0;
        w_inv_nxt   = r_inv;
        w_clr_nxt   = r_clr;

        if (r_state == S_DROP) begin
            w_state_nxt = r_dir ? S_MARCH_R : S_MARCH_L;
        end

        if (w_tick) begin
            w_xoff_nxt = 2'd0;
            w_yoff_nxt = 2'd0;
            if (r_state != S_HALT) begin
                if (alive_count == 6'd0) begin
                    w_clr_nxt   = 1'b1;
                    w_state_nxt = S_HALT;
                end else if (run) begin
                    if (r_state == S_IDLE) begin
                        w_state_nxt = S_MARCH_R;
                    end
                    if (w_fire) begin
                        w_cnt_nxt = 4'd0;
                        w_lim_nxt = (alive_count <= FASTER_THR) ? 4'd1 : BASE_DIV;
                        w_stb_nxt = 1'b1;
                        if (w_edge) begin
                            w_yoff_nxt  = DROP_PX;
                            w_y_nxt     = w_y_after[9:0];
                            w_dir_nxt   = ~r_dir;
                            w_state_nxt = S_DROP;
                        end else begin
                            w_xoff_nxt  = w_s;
                            w_x_nxt     = r_dir ? (r_x + {8'd0, w_s}) : (r_x - {8'd0, w_s});
                            w_state_nxt = r_dir ? S_MARCH_R : S_MARCH_L;
                        end
                        if ((w_y_after + {1'b0, FORM_H}) >= {1'b0, Y_LIMIT}) begin
                            w_inv_nxt   = 1'b1;
                            w_state_nxt = S_HALT;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
        end
    end

    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_lim   <= BASE_DIV;
            r_x     <= START_X;
            r_y     <= START_Y;
            r_dir   <= 1'b1;
            r_xoff  <= 2'd0;
            r_yoff  <= 2'd0;
            r_stb   <= 1'b0;
            r_inv   <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lim   <= w_lim_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_dir   <= w_dir_nxt;
            r_xoff  <= w_xoff_nxt;
            r_yoff  <= w_yoff_nxt;
            r_stb   <= w_stb_nxt;
            r_inv   <= w_inv_nxt;
            r_clr   <= w_clr_nxt;
        end
    end

    assign X_off    = r_xoff;
    assign Y_off    = r_yoff;
    assign Dir      = r_dir;
    assign move_stb = r_stb;
    assign FormX    = r_x;
    assign FormY    = r_y;
    assign invaded  = r_inv;
    assign cleared  = r_clr;

endmodule

// File: tb/tb_alien_march_ctrl.sv
// tb/tb_alien_march_ctrl.sv - scoreboard bench for alien_march_ctrl
module tb_alien_march_ctrl;

    logic       Pclk = 1'b0;
    logic       rst_n;
    logic [9:0] xx, yy;
    logic       run;
    logic [5:0] alive_count;
    logic [1:0] X_off, Y_off;
    logic       Dir, move_stb, invaded, cleared;
    logic [9:0] FormX, FormY;

    alien_march_ctrl dut (
        .Pclk(Pclk), .rst_n(rst_n), .xx(xx), .yy(yy), .run(run),
        .alive_count(alive_count), .X_off(X_off), .Y_off(Y_off), .Dir(Dir),
        .move_stb(move_stb), .FormX(FormX), .FormY(FormY),
        .invaded(invaded), .cleared(cleared)
    );

    always #5 Pclk = ~Pclk;

    typedef struct {
        int xo;
        int yo;
        int dir;
        int x;
        int y;
    } step_t;

    step_t q[$];
    int n_checks = 0;
    int n_err    = 0;
    int n_stb    = 0;

    int m_x, m_y, m_cnt, m_lim;
    bit m_dir, m_halt, m_inv, m_clr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int step_of(input logic [5:0] a);
        if (a <= 6'd4) return 3;
        if (a <= 6'd16) return 2;
        return 1;
    endfunction

    function automatic bit at_edge(input int s);
        if (m_dir) return (m_x + 295 + s) > 634;
        return m_x < (5 + s);
    endfunction

    task automatic model_reset();
        m_x = 135; m_y = 120; m_cnt = 0; m_lim = 3;
        m_dir = 1'b1; m_halt = 1'b0; m_inv = 1'b0; m_clr = 1'b0;
        q.delete();
    endtask

    // Reference behaviour for one frame tick, evaluated with the inputs driven for that tick.
    task automatic model_tick();
        int s;
        if (m_halt) return;
        if (alive_count == 6'd0) begin
            m_clr = 1'b1; m_halt = 1'b1;
            return;
        end
        if (!run) return;
        m_cnt++;
        if (m_cnt < m_lim) return;
        m_cnt = 0;
        s = step_of(alive_count);
        m_lim = (alive_count <= 6'd4) ? 1 : 3;
        if (at_edge(s)) begin
            m_y += 2;
            m_dir = !m_dir;
            q.push_back('{0, 2, int'(m_dir), m_x, m_y});
        end else begin
            m_x = m_dir ? m_x + s : m_x - s;
            q.push_back('{s, 0, int'(m_dir), m_x, m_y});
        end
        if (m_y + 120 >= 440) begin
            m_inv = 1'b1; m_halt = 1'b1;
        end
    endtask

    function automatic bit next_tick_invades();
        int s;
        s = step_of(alive_count);
        if (m_halt || !run || (m_cnt + 1 < m_lim)) return 1'b0;
        return at_edge(s) && (m_y + 2 + 120 >= 440);
    endfunction

    task automatic do_tick();
        @(negedge Pclk);
        xx = 10'd639; yy = 10'd479;
        model_tick();
        @(negedge Pclk);
        xx = 10'd0; yy = 10'd0;
        #1;
    endtask

    task automatic check_reset_values();
        chk("rst_xoff", X_off, 0);
        chk("rst_yoff", Y_off, 0);
        chk("rst_dir", Dir, 1);
        chk("rst_stb", move_stb, 0);
        chk("rst_formx", FormX, 135);
        chk("rst_formy", FormY, 120);
        chk("rst_invaded", invaded, 0);
        chk("rst_cleared", cleared, 0);
    endtask

    always @(negedge Pclk) begin : monitor
        step_t e;
        if (rst_n === 1'b1 && move_stb === 1'b1) begin
            n_stb++;
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL stb_unexpected: move_stb=1 FormX=%0d FormY=%0d with no step queued", FormX, FormY);
            end else begin
                e = q.pop_front();
                chk("sb_xoff", X_off, e.xo);
                chk("sb_yoff", Y_off, e.yo);
                chk("sb_dir", Dir, e.dir);
                chk("sb_formx", FormX, e.x);
                chk("sb_formy", FormY, e.y);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n = 1'b0; run = 1'b0; alive_count = 6'd55; xx = 10'd0; yy = 10'd0;
        model_reset();
        repeat (3) @(negedge Pclk);
        #1;
        check_reset_values();
        @(negedge Pclk);
        rst_n = 1'b1;

        // First step needs three ticks at full formation.
        run = 1'b1;
        n0 = n_stb;
        do_tick(); do_tick();
        chk("no_step_before_3rd", n_stb - n0, 0);
        do_tick();
        chk("first_step_stb", move_stb, 1);
        chk("first_step_formx", FormX, 136);
        chk("first_step_xoff", X_off, 1);
        @(negedge Pclk); #1;
        chk("stb_one_cycle", move_stb, 0);

        // March right until the edge drop.
        for (int i = 0; i < 2000 && m_y == 120; i++) do_tick();
        chk("drop_formy", FormY, 122);
        chk("drop_dir", Dir, 0);
        chk("drop_xoff", X_off, 0);
        chk("drop_yoff", Y_off, 2);
        chk("drop_formx", FormX, 339);
        repeat (3) do_tick();
        chk("after_drop_xoff", X_off, 1);
        chk("after_drop_formx", FormX, 338);

        // Freeze: no steps, offsets cleared on the frozen tick.
        run = 1'b0;
        n0 = n_stb;
        repeat (5) do_tick();
        chk("freeze_no_steps", n_stb - n0, 0);
        chk("freeze_xoff", X_off, 0);
        chk("freeze_formx", FormX, 338);
        run = 1'b1;

        alive_count = 6'd10;
        n0 = n_stb;
        repeat (9) do_tick();
        chk("mid_steps", n_stb - n0, 3);
        chk("mid_xoff", X_off, 2);
        chk("mid_formx", FormX, 332);

        alive_count = 6'd3;
        n0 = n_stb;
        repeat (10) do_tick();
        chk("fast_steps", n_stb - n0, 8);
        chk("fast_xoff", X_off, 3);
        chk("fast_formx", FormX, 308);

        // March to the invasion line.
        for (int i = 0; i < 20000 && !m_inv; i++) do_tick();
        chk("inv_invaded", invaded, 1);
        chk("inv_cleared", cleared, 0);
        chk("inv_formy", FormY, 320);
        n0 = n_stb;
        repeat (4) do_tick();
        chk("halt_no_steps", n_stb - n0, 0);
        chk("halt_xoff", X_off, 0);
        chk("halt_yoff", Y_off, 0);
        chk("sb_drained_1", q.size(), 0);

        // Cleared wins over an invasion on the same tick.
        @(negedge Pclk);
        rst_n = 1'b0; run = 1'b0; alive_count = 6'd3;
        model_reset();
        @(negedge Pclk); #1;
        check_reset_values();
        @(negedge Pclk);
        rst_n = 1'b1; run = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            if (next_tick_invades()) begin
                alive_count = 6'd0;
                do_tick();
                break;
            end
            do_tick();
        end
        chk("clr_cleared", cleared, 1);
        chk("clr_invaded", invaded, 0);
        chk("clr_formy", FormY, 318);
        n0 = n_stb;
        repeat (2) do_tick();
        chk("clr_no_steps", n_stb - n0, 0);
        chk("clr_xoff", X_off, 0);
        chk("sb_drained_2", q.size(), 0);

        // Reset asserted one cycle after a step-firing tick.
        @(negedge Pclk);
        rst_n = 1'b0; alive_count = 6'd55;
        model_reset();
        @(negedge Pclk);
        rst_n = 1'b1;
        do_tick(); do_tick(); do_tick();
        chk("pre_rst_stb", move_stb, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_stb", move_stb, 0);
        chk("async_rst_formx", FormX, 135);
        chk("async_rst_formy", FormY, 120);
        model_reset();
        @(negedge Pclk);
        rst_n = 1'b1;
        n0 = n_stb;
        do_tick(); do_tick();
        chk("post_rst_no_early", n_stb - n0, 0);
        do_tick();
        chk("post_rst_third", n_stb - n0, 1);
        chk("post_rst_formx", FormX, 136);
        chk("sb_drained_3", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
